// File: rtl/axi_mem_pkg.sv
// Shared constants and state encoding for the AXI4 memory responder.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrResp,
    StRdFetch,
    StRdData
  } state_e;

endpackage

// File: rtl/mem_sp_ram.sv
// Single-port synchronous RAM, 64-bit words, byte write enables, registered read.
module mem_sp_ram #(
  parameter int unsigned AddrWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [63:0]          wdata_i,
  input  logic [7:0]           be_i,
  output logic [63:0]          rdata_o
);

  logic [63:0] mem_q [2**AddrWidth];

  // Byte-masked write, or read into the output register; output holds otherwise.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 8; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: one burst at a time, backed by a single-port RAM.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 40,
  parameter int unsigned MEM_DEPTH_LOG2 = 12
) (
  input  logic                  role_to_mem_clk,
  input  logic                  role_to_mem_reset,
  input  logic [ADDR_WIDTH-1:0] axi_role_to_mem_awaddr,
  input  logic [7:0]            axi_role_to_mem_awlen,
  input  logic [2:0]            axi_role_to_mem_awsize,
  input  logic [1:0]            axi_role_to_mem_awburst,
  input  logic                  axi_role_to_mem_awvalid,
  output logic                  axi_role_to_mem_awready,
  input  logic [63:0]           axi_role_to_mem_wdata,
  input  logic [7:0]            axi_role_to_mem_wstrb,
  input  logic                  axi_role_to_mem_wlast,
  input  logic                  axi_role_to_mem_wvalid,
  output logic                  axi_role_to_mem_wready,
  output logic [1:0]            axi_role_to_mem_bresp,
  output logic                  axi_role_to_mem_bvalid,
  input  logic                  axi_role_to_mem_bready,
  input  logic [ADDR_WIDTH-1:0] axi_role_to_mem_araddr,
  input  logic [7:0]            axi_role_to_mem_arlen,
  input  logic [2:0]            axi_role_to_mem_arsize,
  input  logic [1:0]            axi_role_to_mem_arburst,
  input  logic                  axi_role_to_mem_arvalid,
  output logic                  axi_role_to_mem_arready,
  output logic [63:0]           axi_role_to_mem_rdata,
  output logic [1:0]            axi_role_to_mem_rresp,
  output logic                  axi_role_to_mem_rlast,
  output logic                  axi_role_to_mem_rvalid,
  input  logic                  axi_role_to_mem_rready
);

  localparam int unsigned IW = MEM_DEPTH_LOG2;

  // Whole-burst response decided once at acceptance.
  function automatic logic [1:0] accept_resp(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] last_word;
    if (burst != BURST_INCR && burst != BURST_FIXED) return RESP_SLVERR;
    if (addr[ADDR_WIDTH-1:IW+3] != '0) return RESP_DECERR;
    last_word = 32'(addr[IW+2:3]) + ((burst == BURST_INCR) ? 32'(len) : 32'd0);
    if (last_word >= (32'd1 << IW)) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  state_e          state_q, state_d;
  logic            aw_ready_q, aw_ready_d, ar_ready_q, ar_ready_d;
  logic            prefer_wr_q, prefer_wr_d;
  logic [IW-1:0]   idx_q, idx_d, idx_next;
  logic [7:0]      len_q, len_d, cnt_q, cnt_d;
  logic [1:0]      burst_q, burst_d, resp_q, resp_d;
  logic            wlast_err_q, wlast_err_d;
  logic            ram_en, ram_we, last_beat, burst_ok;
  logic [IW-1:0]   ram_addr;
  logic [63:0]     ram_rdata;
  logic            unused;

  assign unused    = ^{axi_role_to_mem_awsize, axi_role_to_mem_arsize,
                       axi_role_to_mem_awaddr[2:0], axi_role_to_mem_araddr[2:0]};
  assign idx_next  = idx_q + {{(IW-1){1'b0}}, burst_q == BURST_INCR};
  assign last_beat = (cnt_q == len_q);
  assign burst_ok  = (resp_q == RESP_OKAY);

  // Arbitration, burst bookkeeping and RAM port control.
  always_comb begin
    state_d     = state_q;
    aw_ready_d  = aw_ready_q;
    ar_ready_d  = ar_ready_q;
    prefer_wr_d = prefer_wr_q;
    idx_d       = idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    resp_d      = resp_q;
    wlast_err_d = wlast_err_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = idx_q;
    case (state_q)
      StIdle: begin
        if (aw_ready_q) begin
          aw_ready_d = 1'b0;
          if (axi_role_to_mem_awvalid) begin
            idx_d       = axi_role_to_mem_awaddr[IW+2:3];
            len_d       = axi_role_to_mem_awlen;
            burst_d     = axi_role_to_mem_awburst;
            resp_d      = accept_resp(axi_role_to_mem_awaddr, axi_role_to_mem_awlen,
                                      axi_role_to_mem_awburst);
            cnt_d       = '0;
            wlast_err_d = 1'b0;
            state_d     = StWrData;
          end
        end else if (ar_ready_q) begin
          ar_ready_d = 1'b0;
          if (axi_role_to_mem_arvalid) begin
            idx_d   = axi_role_to_mem_araddr[IW+2:3];
            len_d   = axi_role_to_mem_arlen;
            burst_d = axi_role_to_mem_arburst;
            resp_d  = accept_resp(axi_role_to_mem_araddr, axi_role_to_mem_arlen,
                                  axi_role_to_mem_arburst);
            cnt_d   = '0;
            state_d = StRdFetch;
          end
        end else if (axi_role_to_mem_awvalid && (!axi_role_to_mem_arvalid || prefer_wr_q)) begin
          aw_ready_d  = 1'b1;
          prefer_wr_d = 1'b0;
        end else if (axi_role_to_mem_arvalid) begin
          ar_ready_d  = 1'b1;
          prefer_wr_d = 1'b1;
        end
      end
      StWrData: begin
        if (axi_role_to_mem_wvalid) begin
          ram_en = burst_ok;
          ram_we = burst_ok;
          cnt_d  = cnt_q + 8'd1;
          idx_d  = idx_next;
          // Wrong wlast only flags the response; the counter still ends the burst.
          if (axi_role_to_mem_wlast != last_beat) wlast_err_d = 1'b1;
          if (last_beat) state_d = StWrResp;
        end
      end
      StWrResp: begin
        if (axi_role_to_mem_bready) state_d = StIdle;
      end
      StRdFetch: begin
        ram_en  = burst_ok;
        state_d = StRdData;
      end
      StRdData: begin
        if (axi_role_to_mem_rready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            // Fetch the next word alongside the handshake so beats stream back to back.
            cnt_d    = cnt_q + 8'd1;
            idx_d    = idx_next;
            ram_en   = burst_ok;
            ram_addr = idx_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; RAM contents are not touched by reset.
  always_ff @(posedge role_to_mem_clk or posedge role_to_mem_reset) begin
    if (role_to_mem_reset) begin
      state_q     <= StIdle;
      aw_ready_q  <= 1'b0;
      ar_ready_q  <= 1'b0;
      prefer_wr_q <= 1'b1;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
      resp_q      <= RESP_OKAY;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_ready_q  <= aw_ready_d;
      ar_ready_q  <= ar_ready_d;
      prefer_wr_q <= prefer_wr_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      resp_q      <= resp_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  mem_sp_ram #(
    .AddrWidth(IW)
  ) u_ram (
    .clk_i  (role_to_mem_clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(axi_role_to_mem_wdata),
    .be_i   (axi_role_to_mem_wstrb),
    .rdata_o(ram_rdata)
  );

  // Channel outputs decode from state so they are zero outside their phase.
  always_comb begin
    axi_role_to_mem_awready = aw_ready_q;
    axi_role_to_mem_arready = ar_ready_q;
    axi_role_to_mem_wready  = (state_q == StWrData);
    axi_role_to_mem_bvalid  = (state_q == StWrResp);
    axi_role_to_mem_bresp   = '0;
    if (state_q == StWrResp) begin
      axi_role_to_mem_bresp = (burst_ok && wlast_err_q) ? RESP_SLVERR : resp_q;
    end
    axi_role_to_mem_rvalid = (state_q == StRdData);
    axi_role_to_mem_rresp  = (state_q == StRdData) ? resp_q : 2'b00;
    axi_role_to_mem_rlast  = (state_q == StRdData) && last_beat;
    axi_role_to_mem_rdata  = (state_q == StRdData && burst_ok) ? ram_rdata : 64'd0;
  end

endmodule
